// File: rtl/upc_checkout_monitor.sv
// -----------------------------------------------------------------------------
// upc_checkout_monitor
//
// Purpose:
//   Clocked checkout monitor. It accepts one item code per cycle on item_valid
//   and looks the code up in the parameter-defined valid, discount and
//   expensive sets. It registers the per-item discount/stolen/invalid flags,
//   keeps saturating statistics counters, and drives a latched theft alarm.
//   The alarm sets once STOLEN_LIMIT stolen items have been seen since the
//   last alarm clear.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   item_valid     in   item_code/marked sampled on this edge
//   item_code      in   [CODE_W] UPC code of the scanned item
//   marked         in   security mark present on the item
//   alarm_clr      in   clears alarm and strike count
//   cnt_clr        in   clears scan/discount/stolen counters
//   out_valid      out  result flags are meaningful this cycle
//   discount       out  item valid and discounted
//   stolen         out  item valid, expensive and unmarked
//   invalid        out  item code not in the valid set
//   alarm          out  latched theft alarm
//   scan_count     out  [CNT_W] valid items accepted (saturating)
//   discount_count out  [CNT_W] discounted items accepted (saturating)
//   stolen_count   out  [CNT_W] stolen items accepted (saturating)
// -----------------------------------------------------------------------------
module upc_checkout_monitor #(
    parameter int                      CODE_W         = 3,
    parameter int                      CNT_W          = 8,
    parameter logic [(1<<CODE_W)-1:0]  DISCOUNT_MASK  = 'hA2,
    parameter logic [(1<<CODE_W)-1:0]  EXPENSIVE_MASK = 'h49,
    parameter logic [(1<<CODE_W)-1:0]  VALID_MASK     = 'h7F,
    parameter int                      STOLEN_LIMIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              item_valid,
    input  logic [CODE_W-1:0] item_code,
    input  logic              marked,
    input  logic              alarm_clr,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic              discount,
    output logic              stolen,
    output logic              invalid,
    output logic              alarm,
    output logic [CNT_W-1:0]  scan_count,
    output logic [CNT_W-1:0]  discount_count,
    output logic [CNT_W-1:0]  stolen_count
);

    localparam int                  STRIKE_W = $clog2(STOLEN_LIMIT + 1);
    localparam logic [STRIKE_W-1:0] LIMIT_S  = STRIKE_W'(STOLEN_LIMIT);

    // ---------------------------------------------------------------------
    // Lookup on the sampled inputs
    // ---------------------------------------------------------------------
    logic is_v;
    logic is_d;
    logic is_s;

    always_comb begin
        is_v = VALID_MASK[item_code];
        is_d = is_v & DISCOUNT_MASK[item_code];
        is_s = is_v & EXPENSIVE_MASK[item_code] & ~marked;
    end

    // ---------------------------------------------------------------------
    // Per-item result flags. They are not held: an idle edge clears them.
    // ---------------------------------------------------------------------
    logic out_valid_reg;
    logic discount_reg;
    logic stolen_reg;
    logic invalid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            discount_reg  <= 1'b0;
            stolen_reg    <= 1'b0;
            invalid_reg   <= 1'b0;
        end else begin
            out_valid_reg <= item_valid;
            discount_reg  <= item_valid & is_d;
            stolen_reg    <= item_valid & is_s;
            invalid_reg   <= item_valid & ~is_v;
        end
    end

    // ---------------------------------------------------------------------
    // Statistics counters: index 0 = scan, 1 = discount, 2 = stolen.
    // cnt_clr wins over an increment on the same edge.
    // ---------------------------------------------------------------------
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg  [3];
    logic [CNT_W-1:0] cnt_next [3];

    assign cnt_inc = {is_s, is_d, is_v};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (cnt_clr) begin
                    cnt_next[gi] = '0;
                end else if (item_valid && cnt_inc[gi] && !(&cnt_reg[gi])) begin
                    cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Strike counter and latched alarm. alarm_clr is applied before the
    // current item, so a stolen item on the clearing edge counts as strike 1.
    // ---------------------------------------------------------------------
    logic [STRIKE_W-1:0] strike_reg;
    logic [STRIKE_W-1:0] strike_base;
    logic [STRIKE_W-1:0] strike_next;
    logic                alarm_reg;
    logic                alarm_next;
    logic                stolen_hit;

    always_comb begin
        stolen_hit  = item_valid & is_s;
        strike_base = alarm_clr ? '0 : strike_reg;
        strike_next = strike_base;
        if (stolen_hit && strike_base != LIMIT_S) begin
            strike_next = strike_base + STRIKE_W'(1);
        end
        alarm_next = alarm_clr ? 1'b0 : alarm_reg;
        if (stolen_hit && strike_next >= LIMIT_S) begin
            alarm_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strike_reg <= '0;
            alarm_reg  <= 1'b0;
        end else begin
            strike_reg <= strike_next;
            alarm_reg  <= alarm_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ---------------------------------------------------------------------
    assign out_valid      = out_valid_reg;
    assign discount       = discount_reg;
    assign stolen         = stolen_reg;
    assign invalid        = invalid_reg;
    assign alarm          = alarm_reg;
    assign scan_count     = cnt_reg[0];
    assign discount_count = cnt_reg[1];
    assign stolen_count   = cnt_reg[2];

endmodule

// File: tb/tb_upc_checkout_monitor.sv
// -----------------------------------------------------------------------------
// tb_upc_checkout_monitor
//
// Directed bench for upc_checkout_monitor. dut uses the default parameters.
// dut_sat uses CNT_W=3 for the saturation case. Both share the same stimulus.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising
// edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_upc_checkout_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       item_valid;
    logic [2:0] item_code;
    logic       marked;
    logic       alarm_clr;
    logic       cnt_clr;

    logic       out_valid, discount, stolen, invalid, alarm;
    logic [7:0] scan_count, discount_count, stolen_count;

    logic       s_out_valid, s_discount, s_stolen, s_invalid, s_alarm;
    logic [2:0] s_scan_count, s_discount_count, s_stolen_count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    upc_checkout_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .item_valid     (item_valid),
        .item_code      (item_code),
        .marked         (marked),
        .alarm_clr      (alarm_clr),
        .cnt_clr        (cnt_clr),
        .out_valid      (out_valid),
        .discount       (discount),
        .stolen         (stolen),
        .invalid        (invalid),
        .alarm          (alarm),
        .scan_count     (scan_count),
        .discount_count (discount_count),
        .stolen_count   (stolen_count)
    );

    upc_checkout_monitor #(.CNT_W(3)) dut_sat (
        .clk            (clk),
        .reset          (reset),
        .item_valid     (item_valid),
        .item_code      (item_code),
        .marked         (marked),
        .alarm_clr      (alarm_clr),
        .cnt_clr        (cnt_clr),
        .out_valid      (s_out_valid),
        .discount       (s_discount),
        .stolen         (s_stolen),
        .invalid        (s_invalid),
        .alarm          (s_alarm),
        .scan_count     (s_scan_count),
        .discount_count (s_discount_count),
        .stolen_count   (s_stolen_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: drive on the falling edge, sample just after the rising edge.
    task automatic step(input logic v, input logic [2:0] code, input logic mk,
                        input logic aclr, input logic cclr);
        @(negedge clk);
        item_valid = v;
        item_code  = code;
        marked     = mk;
        alarm_clr  = aclr;
        cnt_clr    = cclr;
        @(posedge clk);
        #1;
        $display("t=%0t v=%0b code=%0d mk=%0b aclr=%0b cclr=%0b -> ov=%0b d=%0b s=%0b inv=%0b al=%0b scan=%0d disc=%0d stol=%0d",
                 $time, v, code, mk, aclr, cclr, out_valid, discount, stolen, invalid,
                 alarm, scan_count, discount_count, stolen_count);
    endtask

    task automatic chk_flags(input string tag, input logic ov, input logic d,
                             input logic s, input logic inv, input logic al);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".discount"},  32'(discount),  32'(d));
        chk({tag, ".stolen"},    32'(stolen),    32'(s));
        chk({tag, ".invalid"},   32'(invalid),   32'(inv));
        chk({tag, ".alarm"},     32'(alarm),     32'(al));
    endtask

    task automatic chk_cnts(input string tag, input int sc, input int dc, input int stc);
        chk({tag, ".scan_count"},     32'(scan_count),     32'(sc));
        chk({tag, ".discount_count"}, 32'(discount_count), 32'(dc));
        chk({tag, ".stolen_count"},   32'(stolen_count),   32'(stc));
    endtask

    // Hand-derived per-code results for the default masks.
    logic exp_d   [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
    logic exp_s   [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    logic exp_inv [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic exp_al  [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        reset      = 1'b1;
        item_valid = 1'b0;
        item_code  = '0;
        marked     = 1'b0;
        alarm_clr  = 1'b0;
        cnt_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 0, 0, 0, 0, 0);
        chk_cnts("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full code sweep, unmarked
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 3'(c), 1'b0, 1'b0, 1'b0);
            chk_flags($sformatf("sweep%0d", c), 1'b1, exp_d[c], exp_s[c], exp_inv[c], exp_al[c]);
        end
        chk_cnts("sweep_end", 7, 2, 3);

        // Idle edge: flags drop, counts and alarm hold
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_flags("idle", 0, 0, 0, 0, 1);
        chk_cnts("idle", 7, 2, 3);

        // Alarm clear alone
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_flags("aclr", 0, 0, 0, 0, 0);

        // Marked expensive items are not stolen
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        chk_flags("marked0", 1, 0, 0, 0, 0);
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        chk_flags("marked3", 1, 0, 0, 0, 0);
        step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        chk_flags("marked6", 1, 0, 0, 0, 0);
        chk_cnts("marked", 10, 2, 3);

        // Rebuild alarm: two stolen items
        step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_flags("strike1", 1, 0, 1, 0, 0);
        step(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        chk_flags("strike2", 1, 0, 1, 0, 1);

        // Alarm clear together with a stolen item: strike becomes 1, alarm off
        step(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        chk_flags("aclr_race", 1, 0, 1, 0, 0);
        step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
        chk_flags("after_race", 1, 0, 1, 0, 1);
        chk_cnts("after_race", 14, 2, 7);

        // Counter clear together with a valid discounted item
        step(1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        chk_flags("cclr_race", 1, 1, 0, 0, 1);
        chk_cnts("cclr_race", 0, 0, 0);

        // Counters nonzero, then asynchronous reset mid-cycle
        step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        chk_cnts("pre_reset", 1, 1, 0);
        @(negedge clk);
        item_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_flags("async_reset", 0, 0, 0, 0, 0);
        chk_cnts("async_reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk_flags("post_reset", 0, 0, 0, 0, 0);
        chk_cnts("post_reset", 0, 0, 0);

        // Saturation: 10 discounted items into the 3-bit-counter instance
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        end
        chk("sat.scan_count",     32'(s_scan_count),     32'd7);
        chk("sat.discount_count", 32'(s_discount_count), 32'd7);
        chk("sat.stolen_count",   32'(s_stolen_count),   32'd0);
        chk("sat.discount",       32'(s_discount),       32'd1);
        chk_cnts("nosat", 10, 10, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
